// File: rtl/load_store_unit.sv
// Load/store unit: bridges the execute stage and data memory. One request is
// accepted at a time, turned into a word-aligned access with byte enables,
// and answered by a single-cycle response carrying extended load data or an
// error flag (misaligned, illegal funct3, or memory timeout).
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Last counter value before an unacknowledged access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] data_q;
  logic        err_q;

  logic        accept;
  logic        req_illegal;
  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;

  // Pick the addressed byte/halfword out of a memory word and extend it.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_W:    res = word;
      F3_BU:   res = {24'h0, b};
      F3_HU:   res = {16'h0, h};
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_off   = req_addr[1:0];
  assign mem_req   = (state == S_ISSUE);

  // Decode the incoming request: legality, byte enables and replicated store data.
  always_comb begin
    req_illegal   = 1'b0;
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_funct3)
      F3_B:    req_illegal = 1'b0;
      F3_H:    req_illegal = req_off[0];
      F3_W:    req_illegal = (req_off != 2'b00);
      F3_BU:   req_illegal = req_we;
      F3_HU:   req_illegal = req_we | req_off[0];
      default: req_illegal = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        req_be        = 4'b0001 << req_off;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << req_off;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
    endcase
  end

  // Main FSM: capture the request, run the memory access with a timeout, stage the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 8'h0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      data_q    <= 32'h0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= req_off;
            data_q   <= 32'h0;
            if (req_illegal) begin
              err_q <= 1'b1;
              state <= S_RESP;
            end else begin
              err_q     <= 1'b0;
              cnt       <= 8'h0;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= req_be;
              mem_wdata <= req_wdata_rep;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            err_q  <= 1'b0;
            data_q <= we_q ? 32'h0 : extract_load(funct3_q, off_q, mem_rdata);
            state  <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            err_q  <= 1'b1;
            data_q <= 32'h0;
            state  <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Response register: a one-cycle pulse whose data and error are zero outside the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= (state == S_RESP);
      rsp_err   <= (state == S_RESP) & err_q;
      rsp_rdata <= ((state == S_RESP) && !err_q) ? data_q : 32'h0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests with hand-computed
// results; expected responses go into a scoreboard queue that a monitor drains.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   test_id  = 0;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to measure response latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response appears and checks idle zeros otherwise.
  always @(negedge clk) begin
    if (rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput($sformatf("rsp_rdata_t%0d", e.id), rsp_rdata, e.rdata);
          checkOutput($sformatf("rsp_err_t%0d", e.id), {31'h0, rsp_err}, {31'h0, e.err});
          checkOutput($sformatf("rsp_latency_t%0d", e.id), cyc - e.acc_cyc, e.lat);
        end
      end else if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        checkOutput("idle_rsp_zero", {rsp_rdata[30:0], rsp_err}, 32'h0);
      end
    end
  end

  // Present one request at a negedge and return once it has been accepted.
  task automatic issueRequest(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int tries = 0;
    @(negedge clk);
    while (!req_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!req_ready) checkOutput("ready_wait", 32'd0, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Issue one request, play memory (ack after ack_wait wait cycles, -1 = never) and check the bus.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd, input int ack_wait,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                               input logic [31:0] exp_mwdata, input int exp_cycles);
    exp_t e;
    int   n = 0;
    bit   done = 0;
    test_id++;
    issueRequest(we, f3, addr, wdata);
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.acc_cyc = cyc;
    e.lat     = (exp_cycles == 0) ? 1 : exp_cycles + 1;
    e.id      = test_id;
    sb.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (exp_cycles == 0 && c == 0) checkOutput($sformatf("ready_low_t%0d", test_id), {31'h0, req_ready}, 32'd0);
      if (exp_cycles == 0 && c == 1) checkOutput($sformatf("ready_back_t%0d", test_id), {31'h0, req_ready}, 32'd1);
      if (mem_req) begin
        n++;
        if (n == 1) begin
          checkOutput($sformatf("mem_addr_t%0d", test_id), mem_addr, exp_maddr);
          checkOutput($sformatf("mem_be_t%0d", test_id), {28'h0, mem_be}, {28'h0, exp_be});
          checkOutput($sformatf("mem_we_t%0d", test_id), {31'h0, mem_we}, {31'h0, we});
          if (we) checkOutput($sformatf("mem_wdata_t%0d", test_id), mem_wdata, exp_mwdata);
        end
        if (ack_wait >= 0 && n == ack_wait + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end else if (n > 0 || (exp_cycles == 0 && c >= 3)) begin
        done = 1;
      end
    end
    mem_ack = 1'b0;
    checkOutput($sformatf("mem_req_cycles_t%0d", test_id), n, exp_cycles);
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      checkOutput($sformatf("rsp_missing_t%0d", test_id), sb.size(), 0);
      sb.delete();
    end
  endtask

  // Directed sequence: reset, loads, stores, illegal requests, timeout and mid-transaction reset.
  initial begin
    rst        = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h28;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("reset_mem_req", {31'h0, mem_req}, 32'd0);
    checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_be", {28'h0, mem_be}, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_no_accept", {31'h0, mem_req}, 32'd0);

    // Word load, ack in the first issue cycle.
    applyStimulus(0, 3'b010, 32'h28, 32'h0, 32'hABCDEF01, 0, 32'hABCDEF01, 0, 32'h28, 4'hF, 32'h0, 1);
    // Signed then unsigned byte from lane 3, three wait cycles.
    applyStimulus(0, 3'b000, 32'h2B, 32'h0, 32'h80FF1234, 3, 32'hFFFFFF80, 0, 32'h28, 4'h8, 32'h0, 4);
    applyStimulus(0, 3'b100, 32'h2B, 32'h0, 32'h80FF1234, 3, 32'h00000080, 0, 32'h28, 4'h8, 32'h0, 4);
    // Positive signed byte from lane 0.
    applyStimulus(0, 3'b000, 32'h20, 32'h0, 32'h1234567F, 0, 32'h0000007F, 0, 32'h20, 4'h1, 32'h0, 1);
    // Halfword store to the upper half.
    applyStimulus(1, 3'b001, 32'h52, 32'h1234BEEF, 32'h0, 1, 32'h0, 0, 32'h50, 4'hC, 32'hBEEFBEEF, 2);
    // Byte and word stores.
    applyStimulus(1, 3'b000, 32'h61, 32'h000000A5, 32'h0, 0, 32'h0, 0, 32'h60, 4'h2, 32'hA5A5A5A5, 1);
    applyStimulus(1, 3'b010, 32'h70, 32'hDEADBEEF, 32'h0, 2, 32'h0, 0, 32'h70, 4'hF, 32'hDEADBEEF, 3);
    // Illegal: misaligned word, reserved funct3, unsigned store, odd halfword.
    applyStimulus(0, 3'b010, 32'h42, 32'h0, 32'h0, -1, 32'h0, 1, 32'h0, 4'h0, 32'h0, 0);
    applyStimulus(0, 3'b011, 32'h40, 32'h0, 32'h0, -1, 32'h0, 1, 32'h0, 4'h0, 32'h0, 0);
    applyStimulus(1, 3'b100, 32'h20, 32'h55, 32'h0, -1, 32'h0, 1, 32'h0, 4'h0, 32'h0, 0);
    applyStimulus(0, 3'b001, 32'h31, 32'h0, 32'h0, -1, 32'h0, 1, 32'h0, 4'h0, 32'h0, 0);
    // Timeout: no ack ever, fifteen request cycles then an error.
    applyStimulus(0, 3'b010, 32'h10, 32'h0, 32'h0, -1, 32'h0, 1, 32'h10, 4'hF, 32'h0, 15);
    // A stray ack while idle must do nothing.
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("stray_ack_mem_req", {31'h0, mem_req}, 32'd0);
    checkOutput("stray_ack_rsp", {31'h0, rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("stray_ack_rsp_late", {31'h0, rsp_valid}, 32'd0);
    // Halfword loads after the timeout, signed upper and unsigned lower.
    applyStimulus(0, 3'b001, 32'h36, 32'h0, 32'h80017FFE, 1, 32'hFFFF8001, 0, 32'h34, 4'hC, 32'h0, 2);
    applyStimulus(0, 3'b101, 32'h34, 32'h0, 32'h80017FFE, 0, 32'h00007FFE, 0, 32'h34, 4'h3, 32'h0, 1);

    // Reset during the second issue cycle.
    issueRequest(0, 3'b010, 32'h28, 32'h0);
    @(negedge clk);
    checkOutput("rst_mid_issue1", {31'h0, mem_req}, 32'd1);
    @(negedge clk);
    checkOutput("rst_mid_issue2", {31'h0, mem_req}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_mem_req_drop", {31'h0, mem_req}, 32'd0);
    checkOutput("rst_mid_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    checkOutput("rst_mid_no_rsp", {31'h0, rsp_valid}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    rst       = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("rst_late_ack_rsp", {31'h0, rsp_valid}, 32'd0);
    checkOutput("rst_late_ack_req", {31'h0, mem_req}, 32'd0);
    checkOutput("rst_release_ready", {31'h0, req_ready}, 32'd1);
    applyStimulus(0, 3'b010, 32'h28, 32'h0, 32'hABCDEF01, 0, 32'hABCDEF01, 0, 32'h28, 4'hF, 32'h0, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage (ALU address result, rs2 data, funct3) and data memory (DMEM).
- Accepts one load/store request at a time over a valid/ready handshake.
- Converts the request into a word-aligned memory access with byte enables, waits a variable number of cycles for the memory acknowledge, then returns sign-/zero-extended load data.
- Flags misaligned accesses, illegal funct3 and memory timeout as errors.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_addr.
- TIMEOUT_CYCLES, 15, maximum cycles mem_req stays high without mem_ack before the access is aborted (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data (0 for stores and errors).
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal funct3 or timeout.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word address, bits[1:0]=00.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory done; mem_rdata valid in the same cycle for loads.
- mem_rdata  in  32  memory read word.

Behaviour:
- Reset (rst=0, asynchronous):
  - State becomes IDLE.
  - rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be and mem_wdata all become 0.
  - Timeout counter becomes 0.
  - req_ready=1, but no request is accepted while rst=0.
- Accept: req_valid & req_ready at a rising edge. addr, we, funct3 and wdata are captured into internal registers; the inputs may change afterwards.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE, accepting a legal request -> ISSUE.
  - IDLE, accepting an illegal request -> RESP with err=1.
    - Illegal means: funct3 not in {000,001,010,100,101}; funct3 with bit2=1 on a store; H/HU with addr[0]=1; W with addr[1:0]!=00.
    - mem_req is never asserted for an illegal request.
  - ISSUE: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable.
    - mem_ack=1 -> RESP, latching load data.
    - Counter reaches TIMEOUT_CYCLES-1 with no ack -> RESP with err=1.
    - Counter increments each cycle in ISSUE and is cleared on entry to ISSUE.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. rsp has no backpressure.
- mem_ack is ignored outside ISSUE.
- Minimum latency: accept at edge N; mem_req high during cycle N..N+1; ack in that cycle; rsp_valid high for cycle N+2..N+3. A new request can be accepted at edge N+3.
- Error latency: rsp_valid in the cycle after accept.
- Byte enables, with off=addr[1:0]:
  - B/BU: 0001<<off.
  - H/HU: 0011<<off.
  - W: 1111.
  - Loads drive the same mem_be.
- mem_wdata:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction:
  - Byte = mem_rdata[8*off+:8].
  - Half = mem_rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- rsp_rdata and rsp_err hold their values only while rsp_valid=1 and are 0 otherwise.
- Reset mid-transaction: mem_req drops immediately and no response is produced. A memory ack arriving after reset release is ignored (state IDLE).

Test Plan:
- LW addr 0x28, mem_ack in first ISSUE cycle with mem_rdata 0xABCDEF01 -> mem_addr 0x28, be 1111, we 0; rsp_valid 2 cycles after accept; rsp_rdata 0xABCDEF01; err 0.
- LB then LBU at 0x2B, mem_rdata 0x80FF1234, ack after 3 wait cycles -> be 1000; rsp_rdata 0xFFFFFF80 then 0x00000080; mem_req high exactly 4 cycles each.
- SH addr 0x52, wdata 0x1234BEEF -> mem_addr 0x50, be 1100, mem_wdata 0xBEEFBEEF, we 1; rsp_rdata 0; err 0.
- LW 0x42, and separately funct3=011 -> mem_req never asserted; rsp_valid with rsp_err=1 in the cycle after accept; req_ready low only for that cycle.
- LW 0x10 with mem_ack held 0, TIMEOUT_CYCLES=15 -> mem_req high exactly 15 cycles, then rsp_err=1 pulse; a later ack is ignored; the next request is accepted normally.
- Assert rst=0 during the second ISSUE cycle -> mem_req falls without waiting for clk; no rsp_valid; after release, req_ready=1 and LW 0x28 completes correctly.
